// File: rtl/activation_writeback_pkg.sv
// Shared sizing, activation codes and FSM states for the activation write-back stage.
package activation_writeback_pkg;

  localparam int MUL_SIZE      = 4;
  localparam int RES_WIDTH     = 31;
  localparam int ACT_WIDTH     = 7;
  localparam int ACTWB_LATENCY = 3;
  localparam int LEAKY_SHIFT   = 3;

  typedef enum logic [1:0] {
    ACT_PASS,
    ACT_RELU,
    ACT_LEAKY,
    ACT_RSVD
  } act_func_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } wb_state_e;

endpackage

// File: rtl/activation_writeback_act_lane.sv
// Combinational per-lane requantizer: round + arithmetic shift, then activation + saturation.
// ACT_LEAKY is only implemented when ACTWB_LEAKY_RELU_EN is defined; otherwise it is a pass-through.
module act_lane
  import activation_writeback_pkg::*;
#(
  parameter int IN_W  = RES_WIDTH + 1,
  parameter int OUT_W = ACT_WIDTH + 1
) (
  input  logic signed [IN_W-1:0]  raw_i,
  input  logic        [4:0]       shift_i,
  output logic signed [IN_W:0]    shifted_o,
  input  logic signed [IN_W:0]    shifted_i,
  input  act_func_e               func_i,
  output logic signed [OUT_W-1:0] act_o
);

  logic signed [IN_W:0] ext;
  logic signed [IN_W:0] roundInc;
  logic signed [IN_W:0] actVal;
  logic                 overflow;

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    ext      = {raw_i[IN_W-1], raw_i};
    roundInc = '0;
    if (shift_i != 5'd0) begin
      roundInc = {{IN_W{1'b0}}, 1'b1} << (shift_i - 5'd1);
    end
    shifted_o = (ext + roundInc) >>> shift_i;
  end

  always_comb begin
    actVal = shifted_i;
    case (func_i)
      ACT_RELU: begin
        if (shifted_i[IN_W]) actVal = '0;
      end
`ifdef ACTWB_LEAKY_RELU_EN
      ACT_LEAKY: begin
        if (shifted_i[IN_W]) actVal = shifted_i >>> LEAKY_SHIFT;
      end
`endif
      default: actVal = shifted_i;
    endcase

    // Out of range whenever the bits above the output sign bit disagree with it.
    overflow = !((&actVal[IN_W:OUT_W-1]) || !(|actVal[IN_W:OUT_W-1]));
    if (!overflow) begin
      act_o = actVal[OUT_W-1:0];
    end else if (actVal[IN_W]) begin
      act_o = {1'b1, {(OUT_W-1){1'b0}}};
    end else begin
      act_o = {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/activation_writeback.sv
// Reads accumulator rows, requantizes each lane and writes the row into the unified buffer.
// Define ACTWB_LEAKY_RELU_EN to build the leaky-ReLU activation.
module activation_writeback
  import activation_writeback_pkg::*;
#(
  parameter int LANES  = MUL_SIZE,
  parameter int IN_W   = RES_WIDTH + 1,
  parameter int OUT_W  = ACT_WIDTH + 1,
  parameter int ACC_AW = 10,
  parameter int UB_AW  = 12
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [7:0]                  cmd_rows_i,
  input  logic [ACC_AW-1:0]           cmd_acc_addr_i,
  input  logic [UB_AW-1:0]            cmd_ub_addr_i,
  input  logic [1:0]                  cmd_func_i,
  input  logic [4:0]                  cmd_shift_i,
  input  logic                        stall_i,
  input  logic [LANES-1:0][IN_W-1:0]  accum_data_i,
  output logic [ACC_AW-1:0]           accum_addr_rd_o,
  output logic                        accum_rd_o,
  output logic                        ub_write_o,
  output logic [UB_AW-1:0]            ub_addr_wr_o,
  output logic [LANES-1:0][OUT_W-1:0] ub_data_o,
  output logic                        busy_o,
  output logic                        done_o
);

  wb_state_e                 state_q;
  logic [7:0]                rows_q;
  logic [ACC_AW-1:0]         accAddr_q;
  logic [UB_AW-1:0]          ubAddr_q;
  act_func_e                 func_q;
  logic [4:0]                shift_q;
  logic                      done_q;

  logic                      rdPend_q;
  logic                      skidV_q;
  logic [LANES-1:0][IN_W-1:0] skid_q;
  logic                      s1V_q;
  logic [LANES-1:0][IN_W:0]  s1_q;
  logic [LANES-1:0][IN_W:0]  s1_d;
  logic                      s2V_q;
  logic [LANES-1:0][OUT_W-1:0] s2_q;
  logic [LANES-1:0][OUT_W-1:0] s2_d;

  logic issue;
  logic wrAccept;

  assign issue    = (state_q == RUN) && !stall_i;
  assign wrAccept = s2V_q && !stall_i;

  assign accum_rd_o      = issue;
  assign accum_addr_rd_o = accAddr_q;
  assign ub_write_o      = s2V_q;
  assign ub_addr_wr_o    = ubAddr_q;
  assign ub_data_o       = s2_q;
  assign busy_o          = (state_q != IDLE);
  assign done_o          = done_q;

  // Command FSM; DRAIN finishes in the cycle the final row is accepted so done follows it directly.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      rows_q    <= '0;
      accAddr_q <= '0;
      ubAddr_q  <= '0;
      func_q    <= ACT_PASS;
      shift_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wrAccept) ubAddr_q <= ubAddr_q + UB_AW'(1);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (cmd_rows_i == 8'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              rows_q    <= cmd_rows_i;
              accAddr_q <= cmd_acc_addr_i;
              ubAddr_q  <= cmd_ub_addr_i;
              func_q    <= act_func_e'(cmd_func_i);
              shift_q   <= cmd_shift_i;
            end
          end
        end
        RUN: begin
          if (!stall_i) begin
            accAddr_q <= accAddr_q + ACC_AW'(1);
            rows_q    <= rows_q - 8'd1;
            if (rows_q == 8'd1) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!stall_i && !rdPend_q && !skidV_q && !s1V_q) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The accumulator keeps returning data during a stall, so a late row lands in the skid register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdPend_q <= 1'b0;
      skidV_q  <= 1'b0;
      skid_q   <= '0;
      s1V_q    <= 1'b0;
      s1_q     <= '0;
      s2V_q    <= 1'b0;
      s2_q     <= '0;
    end else begin
      rdPend_q <= issue;
      if (stall_i) begin
        if (rdPend_q) begin
          skidV_q <= 1'b1;
          skid_q  <= accum_data_i;
        end
      end else begin
        skidV_q <= 1'b0;
        s1V_q   <= skidV_q || rdPend_q;
        s1_q    <= s1_d;
        s2V_q   <= s1V_q;
        if (s1V_q) s2_q <= s2_d;
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : gLane
    act_lane #(
      .IN_W (IN_W),
      .OUT_W(OUT_W)
    ) uLane (
      .raw_i    (skidV_q ? skid_q[l] : accum_data_i[l]),
      .shift_i  (shift_q),
      .shifted_o(s1_d[l]),
      .shifted_i(s1_q[l]),
      .func_i   (func_q),
      .act_o    (s2_d[l])
    );
  end

endmodule

// File: tb/tb_activation_writeback.sv
// Randomized self-checking bench for activation_writeback with a queue-based reference model.
// Honours ACTWB_LEAKY_RELU_EN the same way the design does.
module tb_activation_writeback;
  import activation_writeback_pkg::*;

  localparam int LANES     = MUL_SIZE;
  localparam int IN_W      = RES_WIDTH + 1;
  localparam int OUT_W     = ACT_WIDTH + 1;
  localparam int ACC_AW    = 10;
  localparam int UB_AW     = 12;
  localparam int ACC_DEPTH = 1 << ACC_AW;
  localparam int UB_DEPTH  = 1 << UB_AW;
`ifdef ACTWB_LEAKY_RELU_EN
  localparam bit LEAKY_EN = 1'b1;
`else
  localparam bit LEAKY_EN = 1'b0;
`endif

  logic                        clk_i = 1'b0;
  logic                        rst_i;
  logic                        start_i;
  logic [7:0]                  cmd_rows_i;
  logic [ACC_AW-1:0]           cmd_acc_addr_i;
  logic [UB_AW-1:0]            cmd_ub_addr_i;
  logic [1:0]                  cmd_func_i;
  logic [4:0]                  cmd_shift_i;
  logic                        stall_i;
  logic [LANES-1:0][IN_W-1:0]  accum_data_i;
  logic [ACC_AW-1:0]           accum_addr_rd_o;
  logic                        accum_rd_o;
  logic                        ub_write_o;
  logic [UB_AW-1:0]            ub_addr_wr_o;
  logic [LANES-1:0][OUT_W-1:0] ub_data_o;
  logic                        busy_o;
  logic                        done_o;

  activation_writeback #(
    .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .ACC_AW(ACC_AW), .UB_AW(UB_AW)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .cmd_rows_i(cmd_rows_i),
    .cmd_acc_addr_i(cmd_acc_addr_i), .cmd_ub_addr_i(cmd_ub_addr_i),
    .cmd_func_i(cmd_func_i), .cmd_shift_i(cmd_shift_i), .stall_i(stall_i),
    .accum_data_i(accum_data_i), .accum_addr_rd_o(accum_addr_rd_o),
    .accum_rd_o(accum_rd_o), .ub_write_o(ub_write_o), .ub_addr_wr_o(ub_addr_wr_o),
    .ub_data_o(ub_data_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int                          addr;
    logic [LANES-1:0][OUT_W-1:0] data;
  } wr_t;

  int     checks = 0;
  int     failures = 0;
  int     accMem [ACC_DEPTH][LANES];
  int     expRd[$];
  wr_t    expWr[$];
  bit     modelBusy = 1'b0;
  bit     doneDue = 1'b0;
  int     doneCount = 0;
  int     rdCount = 0;
  int     wrCount = 0;
  int     rawWrCount = 0;
  longint cycleCnt = 0;
  longint firstRdCycle = 0;
  longint firstWrCycle = 0;
  int     lastRdAddr = 0;
  int     lastWrAddr = 0;
  logic [LANES-1:0][OUT_W-1:0] lastWrData;

  bit     cmpExpDone;
  int     cmpA;
  wr_t    cmpW;
  bit     tbRdPend = 1'b0;
  int     tbRdAddr = 0;

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Requantization straight from the arithmetic rules, in 64-bit integers.
  function automatic longint modelLane(input longint x, input int sh, input int fn);
    longint v;
    longint lo;
    longint hi;
    lo = -(longint'(1) <<< (OUT_W - 1));
    hi = (longint'(1) <<< (OUT_W - 1)) - 1;
    v = x;
    if (sh > 0) v = v + (longint'(1) <<< (sh - 1));
    v = v >>> sh;
    if (fn == 1 && v < 0) v = 0;
    else if (fn == 2 && LEAKY_EN && v < 0) v = v >>> LEAKY_SHIFT;
    if (v > hi) v = hi;
    else if (v < lo) v = lo;
    return v;
  endfunction

  function automatic void acceptCmd(input int rows, input int acc, input int ub, input int fn, input int sh);
    wr_t w;
    int  a;
    for (int i = 0; i < rows; i++) begin
      a = (acc + i) % ACC_DEPTH;
      expRd.push_back(a);
      w.addr = (ub + i) % UB_DEPTH;
      for (int l = 0; l < LANES; l++) w.data[l] = OUT_W'(modelLane(longint'(accMem[a][l]), sh, fn));
      expWr.push_back(w);
    end
  endfunction

  function automatic int randVal();
    case ($urandom_range(0, 3))
      0: return int'($urandom_range(0, 400)) - 200;
      1: return int'($urandom_range(0, 20000)) - 10000;
      2: return int'($urandom);
      default: return ($urandom_range(0, 1) != 0) ? 32'sh7fffffff : 32'sh80000000;
    endcase
  endfunction

  // Accumulator stand-in: data for a read appears the cycle after it, garbage otherwise.
  always @(negedge clk_i) begin
    for (int l = 0; l < LANES; l++) begin
      if (tbRdPend) accum_data_i[l] = accMem[tbRdAddr][l];
      else accum_data_i[l] = $urandom;
    end
    tbRdPend = accum_rd_o && !rst_i;
    tbRdAddr = int'(accum_addr_rd_o);
  end

  // Single compare process: checks every DUT output each cycle against the model.
  always @(negedge clk_i) begin
    cycleCnt++;
    if (rst_i) begin
      expRd.delete();
      expWr.delete();
      modelBusy = 1'b0;
      doneDue   = 1'b0;
      checkOutput("reset_rd", accum_rd_o, 0);
      checkOutput("reset_rd_addr", accum_addr_rd_o, 0);
      checkOutput("reset_wr", ub_write_o, 0);
      checkOutput("reset_wr_addr", ub_addr_wr_o, 0);
      checkOutput("reset_wr_data", ub_data_o, 0);
      checkOutput("reset_busy", busy_o, 0);
      checkOutput("reset_done", done_o, 0);
    end else begin
      cmpExpDone = doneDue;
      doneDue = 1'b0;
      if (cmpExpDone) modelBusy = 1'b0;
      checkOutput("done", done_o, cmpExpDone);
      checkOutput("busy", busy_o, modelBusy);
      if (done_o) begin
        doneCount++;
        if (cmpExpDone) checkOutput("reads_left_at_done", expRd.size(), 0);
      end
      if (accum_rd_o) begin
        if (expRd.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_read actual=%0d required=none", accum_addr_rd_o);
        end else begin
          cmpA = expRd.pop_front();
          checkOutput("rd_addr", accum_addr_rd_o, cmpA);
          if (rdCount == 0) firstRdCycle = cycleCnt;
          rdCount++;
          lastRdAddr = int'(accum_addr_rd_o);
        end
      end
      if (ub_write_o && !stall_i) begin
        rawWrCount++;
        if (expWr.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_write actual=%0d required=none", ub_addr_wr_o);
        end else begin
          cmpW = expWr.pop_front();
          checkOutput("wr_addr", ub_addr_wr_o, cmpW.addr);
          checkOutput("wr_data", ub_data_o, cmpW.data);
          if (wrCount == 0) firstWrCycle = cycleCnt;
          wrCount++;
          lastWrAddr = int'(ub_addr_wr_o);
          lastWrData = ub_data_o;
          if (expWr.size() == 0) doneDue = 1'b1;
        end
      end
      if (start_i && !modelBusy) begin
        if (cmd_rows_i == 8'd0) doneDue = 1'b1;
        else begin
          acceptCmd(int'(cmd_rows_i), int'(cmd_acc_addr_i), int'(cmd_ub_addr_i),
                    int'(cmd_func_i), int'(cmd_shift_i));
          modelBusy = 1'b1;
        end
      end
    end
  end

  task automatic applyStimulus(input int rows, input int acc, input int ub, input int fn, input int sh);
    rdCount = 0;
    wrCount = 0;
    @(posedge clk_i); #1;
    start_i        = 1'b1;
    cmd_rows_i     = 8'(rows);
    cmd_acc_addr_i = ACC_AW'(acc);
    cmd_ub_addr_i  = UB_AW'(ub);
    cmd_func_i     = 2'(fn);
    cmd_shift_i    = 5'(sh);
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  task automatic waitDone(input int stallPct, input int maxCycles);
    int startCnt;
    int n;
    startCnt = doneCount;
    n = 0;
    while (doneCount == startCnt && n < maxCycles) begin
      @(posedge clk_i); #1;
      stall_i = (stallPct > 0) && (int'($urandom_range(0, 99)) < stallPct);
      n++;
    end
    stall_i = 1'b0;
    if (doneCount == startCnt) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout actual=none required=done within %0d cycles", maxCycles);
    end
  endtask

  initial begin
    int n;
    int vals[LANES];
    rst_i = 1'b1;
    start_i = 1'b0;
    stall_i = 1'b0;
    cmd_rows_i = '0;
    cmd_acc_addr_i = '0;
    cmd_ub_addr_i = '0;
    cmd_func_i = '0;
    cmd_shift_i = '0;
    for (int a = 0; a < ACC_DEPTH; a++)
      for (int l = 0; l < LANES; l++) accMem[a][l] = randVal();

    // Pin the model to hand-computed values.
    checkOutput("pin_pass_pos", modelLane(5, 0, 0), 5);
    checkOutput("pin_pass_sat_hi", modelLane(300, 0, 0), 127);
    checkOutput("pin_pass_sat_lo", modelLane(-300, 0, 0), -128);
    checkOutput("pin_relu_round", modelLane(24, 4, 1), 2);
    checkOutput("pin_relu_neg", modelLane(-24, 4, 1), 0);
    checkOutput("pin_relu_half", modelLane(8, 4, 1), 1);
    checkOutput("pin_leaky", modelLane(-80, 0, 2), LEAKY_EN ? -10 : -80);

    repeat (3) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Pass-through with saturation, and pipeline latency.
    vals = '{5, -7, 300, -300};
    for (int r = 0; r < 4; r++)
      for (int l = 0; l < LANES; l++) accMem[r][l] = vals[l];
    applyStimulus(4, 0, 100, 0, 0);
    waitDone(0, 50);
    checkOutput("t1_writes", wrCount, 4);
    checkOutput("t1_latency", firstWrCycle - firstRdCycle, ACTWB_LATENCY);
    checkOutput("t1_last_addr", lastWrAddr, 103);
    checkOutput("t1_lane0", longint'(signed'(lastWrData[0])), 5);
    checkOutput("t1_lane1", longint'(signed'(lastWrData[1])), -7);
    checkOutput("t1_lane2", longint'(signed'(lastWrData[2])), 127);
    checkOutput("t1_lane3", longint'(signed'(lastWrData[3])), -128);

    // ReLU with rounding shift.
    vals = '{24, -24, 7, 8};
    for (int l = 0; l < LANES; l++) accMem[10][l] = vals[l];
    applyStimulus(1, 10, 20, 1, 4);
    waitDone(0, 50);
    checkOutput("t2_lane0", longint'(signed'(lastWrData[0])), 2);
    checkOutput("t2_lane1", longint'(signed'(lastWrData[1])), 0);
    checkOutput("t2_lane2", longint'(signed'(lastWrData[2])), 0);
    checkOutput("t2_lane3", longint'(signed'(lastWrData[3])), 1);

    // Three-cycle stall starting one cycle after the second read.
    applyStimulus(8, 40, 600, 0, 3);
    n = 0;
    while (rdCount < 2 && n < 50) begin
      @(negedge clk_i); #1;
      n++;
    end
    checkOutput("t3_second_read_seen", rdCount >= 2, 1);
    @(posedge clk_i); #1;
    stall_i = 1'b1;
    repeat (3) begin
      @(posedge clk_i); #1;
    end
    stall_i = 1'b0;
    waitDone(0, 100);
    checkOutput("t3_writes", wrCount, 8);
    checkOutput("t3_last_addr", lastWrAddr, 607);

    // Address wrap on both sides.
    applyStimulus(4, 1022, 4094, 0, 0);
    waitDone(0, 50);
    checkOutput("t4_last_rd", lastRdAddr, 1);
    checkOutput("t4_last_wr", lastWrAddr, 1);
    checkOutput("t4_writes", wrCount, 4);

    // Zero-row command.
    applyStimulus(0, 5, 5, 0, 0);
    waitDone(0, 10);
    checkOutput("t5_reads", rdCount, 0);
    checkOutput("t5_writes", wrCount, 0);

    // Start while busy is ignored.
    applyStimulus(6, 200, 300, 0, 2);
    @(posedge clk_i); #1;
    start_i = 1'b1;
    cmd_rows_i = 8'd3;
    cmd_acc_addr_i = ACC_AW'(500);
    cmd_ub_addr_i = UB_AW'(900);
    @(posedge clk_i); #1;
    start_i = 1'b0;
    waitDone(0, 50);
    checkOutput("t6_writes", wrCount, 6);

    // Leaky activation.
    accMem[700][0] = -80;
    applyStimulus(1, 700, 50, 2, 0);
    waitDone(0, 50);
    checkOutput("t7_leaky", longint'(signed'(lastWrData[0])), LEAKY_EN ? -10 : -80);

    // Randomized commands under random stalls.
    for (int k = 0; k < 12; k++) begin
      n = int'($urandom_range(1, 12));
      applyStimulus(n, int'($urandom_range(0, ACC_DEPTH - 1)), int'($urandom_range(0, UB_DEPTH - 1)),
                    int'($urandom_range(0, 3)),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 10)));
      waitDone(30, 400);
      checkOutput("rand_writes", wrCount, n);
    end

    // Reset in the middle of a run after two writes.
    applyStimulus(10, 300, 1000, 0, 1);
    n = 0;
    while (wrCount < 2 && n < 50) begin
      @(negedge clk_i); #1;
      n++;
    end
    checkOutput("t8_two_writes_seen", wrCount, 2);
    rst_i = 1'b1;
    #1;
    checkOutput("t8_rst_wr", ub_write_o, 0);
    checkOutput("t8_rst_rd", accum_rd_o, 0);
    checkOutput("t8_rst_busy", busy_o, 0);
    checkOutput("t8_rst_done", done_o, 0);
    checkOutput("t8_rst_data", ub_data_o, 0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    n = rawWrCount;
    repeat (20) @(posedge clk_i);
    checkOutput("t8_no_writes_after_reset", rawWrCount - n, 0);
    checkOutput("t8_idle_after_reset", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #300000;
    failures++;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
